// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS frequency-step controller.
package dds_pkg;

    localparam int NUM_COARSE   = 16;
    localparam int COARSE_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD_UP = 2'd1,
        HOLD_DN = 2'd2
    } state_t;

    localparam logic [2:0] LED_IDLE    = 3'b001;
    localparam logic [2:0] LED_HOLD_UP = 3'b010;
    localparam logic [2:0] LED_HOLD_DN = 3'b100;

    function automatic logic [2:0] state_leds(input state_t s);
        case (s)
            HOLD_UP: state_leds = LED_HOLD_UP;
            HOLD_DN: state_leds = LED_HOLD_DN;
            default: state_leds = LED_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/dds_freq_step_controller_if.sv
// Register-side controls and DDS-side increment outputs of the step controller.
interface dds_freq_step_controller_if #(
    parameter int INC_WIDTH = 32
);
    import dds_pkg::*;

    logic                                   i_enable;
    logic                                   i_tipo_ajuste;
    logic [NUM_COARSE-1:0][INC_WIDTH-1:0]   i_rom_incremento_grueso;
    logic [INC_WIDTH-1:0]                   o_incremento;
    logic                                   o_inc_update;

    modport master (
        output i_enable, i_tipo_ajuste, i_rom_incremento_grueso,
        input  o_incremento, o_inc_update
    );

    modport slave (
        input  i_enable, i_tipo_ajuste, i_rom_incremento_grueso,
        output o_incremento, o_inc_update
    );

endinterface

// File: rtl/key_debouncer.sv
// Two-flop synchronizer, stable-sample debouncer and press (1->0) pulse for one active-low key.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_250_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key,
    output logic o_level,
    output logic o_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    // The counter only runs while the synchronized sample disagrees with the accepted level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            level_reg <= 1'b1;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= i_key;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt_reg   <= '0;
                level_reg <= sync2_reg;
                press_reg <= ~sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign o_level = level_reg;
    assign o_press = press_reg;

endmodule

// File: rtl/dds_freq_step_controller.sv
// Key-driven press/hold/auto-repeat stepping of a coarse table index and a signed fine offset.
module dds_freq_step_controller
    import dds_pkg::*;
#(
    parameter int INC_WIDTH       = 32,
    parameter int FINE_WIDTH      = 8,
    parameter int FINE_STEP       = 1,
    parameter int DEBOUNCE_CYCLES = 1_250_000,
    parameter int REPEAT_CYCLES   = 31_250_000
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_aumentar,
    input  logic                       i_disminuir,
    dds_freq_step_controller_if.slave  bus,
    output logic [2:0]                 o_leds_fino,
    output logic [2:0]                 o_leds_grueso
);

    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0]        REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [COARSE_IDX_W-1:0] IDX_MAX  = COARSE_IDX_W'(NUM_COARSE - 1);
    localparam logic [FINE_WIDTH-1:0]   OFF_MAX  = {1'b0, {(FINE_WIDTH-1){1'b1}}};
    localparam logic [FINE_WIDTH-1:0]   OFF_MIN  = {1'b1, {(FINE_WIDTH-1){1'b0}}};
    localparam logic [INC_WIDTH-1:0]    STEP_V   = INC_WIDTH'(FINE_STEP);

    // Bit 0 is aumentar (up), bit 1 is disminuir (down).
    logic [1:0] key_raw;
    logic [1:0] key_level;
    logic [1:0] key_press;

    assign key_raw = {i_disminuir, i_aumentar};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            key_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debouncer (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_key   (key_raw[gi]),
                .o_level (key_level[gi]),
                .o_press (key_press[gi])
            );
        end
    endgenerate

    state_t                  state_reg, state_next;
    logic [REP_W-1:0]        rep_cnt_reg, rep_cnt_next;
    logic                    step_up_reg, step_up_next;
    logic                    step_dn_reg, step_dn_next;
    logic                    step_coarse_reg;
    logic                    mode_dly_reg;
    logic                    mode_changed;

    assign mode_changed = bus.i_tipo_ajuste != mode_dly_reg;

    always_comb begin
        state_next   = state_reg;
        rep_cnt_next = rep_cnt_reg;
        step_up_next = 1'b0;
        step_dn_next = 1'b0;
        if (!bus.i_enable) begin
            state_next   = IDLE;
            rep_cnt_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    rep_cnt_next = '0;
                    if (key_press[0] && key_level[1]) begin
                        state_next   = HOLD_UP;
                        step_up_next = 1'b1;
                    end else if (key_press[1] && key_level[0]) begin
                        state_next   = HOLD_DN;
                        step_dn_next = 1'b1;
                    end
                end
                HOLD_UP, HOLD_DN: begin
                    // Leaving on release, on both keys down, or on a mode flip.
                    if (mode_changed || (key_level != 2'b10 && state_reg == HOLD_UP)
                                     || (key_level != 2'b01 && state_reg == HOLD_DN)) begin
                        state_next   = IDLE;
                        rep_cnt_next = '0;
                    end else if (rep_cnt_reg == REP_LAST) begin
                        rep_cnt_next = '0;
                        step_up_next = (state_reg == HOLD_UP);
                        step_dn_next = (state_reg == HOLD_DN);
                    end else begin
                        rep_cnt_next = rep_cnt_reg + REP_W'(1);
                    end
                end
                default: begin
                    state_next   = IDLE;
                    rep_cnt_next = '0;
                end
            endcase
        end
    end

    logic [COARSE_IDX_W-1:0] index_reg, index_next;
    logic [FINE_WIDTH-1:0]   offset_reg, offset_next;
    logic                    changed;
    logic                    step_en;
    logic [INC_WIDTH-1:0]    fine_ext;
    logic [INC_WIDTH-1:0]    incremento_reg, incremento_next;
    logic                    inc_update_reg;
    logic [2:0]              leds_fino_reg, leds_grueso_reg;

    // A step is dropped if the mode flipped between request and application.
    assign step_en = bus.i_enable && (step_coarse_reg == bus.i_tipo_ajuste);

    always_comb begin
        index_next  = index_reg;
        offset_next = offset_reg;
        changed     = 1'b0;
        if (step_en) begin
            if (bus.i_tipo_ajuste) begin
                if (step_up_reg && index_reg != IDX_MAX) begin
                    index_next = index_reg + COARSE_IDX_W'(1);
                    changed    = 1'b1;
                end else if (step_dn_reg && index_reg != '0) begin
                    index_next = index_reg - COARSE_IDX_W'(1);
                    changed    = 1'b1;
                end
            end else begin
                if (step_up_reg && offset_reg != OFF_MAX) begin
                    offset_next = offset_reg + FINE_WIDTH'(1);
                    changed     = 1'b1;
                end else if (step_dn_reg && offset_reg != OFF_MIN) begin
                    offset_next = offset_reg - FINE_WIDTH'(1);
                    changed     = 1'b1;
                end
            end
        end
        fine_ext        = {{(INC_WIDTH-FINE_WIDTH){offset_next[FINE_WIDTH-1]}}, offset_next};
        incremento_next = bus.i_rom_incremento_grueso[index_next] + fine_ext * STEP_V;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg       <= IDLE;
            rep_cnt_reg     <= '0;
            step_up_reg     <= 1'b0;
            step_dn_reg     <= 1'b0;
            step_coarse_reg <= 1'b0;
            mode_dly_reg    <= 1'b0;
            index_reg       <= '0;
            offset_reg      <= '0;
            incremento_reg  <= '0;
            inc_update_reg  <= 1'b0;
            leds_fino_reg   <= '0;
            leds_grueso_reg <= '0;
        end else begin
            state_reg       <= state_next;
            rep_cnt_reg     <= rep_cnt_next;
            step_up_reg     <= step_up_next;
            step_dn_reg     <= step_dn_next;
            step_coarse_reg <= bus.i_tipo_ajuste;
            mode_dly_reg    <= bus.i_tipo_ajuste;
            index_reg       <= index_next;
            offset_reg      <= offset_next;
            incremento_reg  <= incremento_next;
            inc_update_reg  <= changed;
            leds_fino_reg   <= bus.i_tipo_ajuste ? 3'b000 : state_leds(state_reg);
            leds_grueso_reg <= bus.i_tipo_ajuste ? state_leds(state_reg) : 3'b000;
        end
    end

    assign bus.o_incremento = incremento_reg;
    assign bus.o_inc_update = inc_update_reg;
    assign o_leds_fino      = leds_fino_reg;
    assign o_leds_grueso    = leds_grueso_reg;

endmodule

// File: tb/tb_dds_freq_step_controller.sv
// Directed bench: key press/hold/repeat, saturation, wrap, simultaneous keys, enable, mode and reset.
module tb_dds_freq_step_controller;
    import dds_pkg::*;

    localparam int INC_WIDTH = 32;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       aumentar  = 1'b1;
    logic       disminuir = 1'b1;
    logic [2:0] leds_fino;
    logic [2:0] leds_grueso;

    dds_freq_step_controller_if #(.INC_WIDTH(INC_WIDTH)) bus ();

    dds_freq_step_controller #(
        .INC_WIDTH       (INC_WIDTH),
        .FINE_WIDTH      (8),
        .FINE_STEP       (1),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (16)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_aumentar    (aumentar),
        .i_disminuir   (disminuir),
        .bus           (bus.slave),
        .o_leds_fino   (leds_fino),
        .o_leds_grueso (leds_grueso)
    );

    always #5 clk = ~clk;

    int   checks    = 0;
    int   errors    = 0;
    int   pulse_cnt = 0;
    int   dbl_cnt   = 0;
    int   cyc       = 0;
    logic prev_upd  = 1'b0;
    int   pulse_t[$];

    // Pulse monitor: counts update pulses, their cycle numbers and back-to-back pulses.
    always @(negedge clk) begin
        cyc++;
        if (rst_n && bus.o_inc_update) begin
            pulse_cnt++;
            pulse_t.push_back(cyc);
            if (prev_upd) dbl_cnt++;
        end
        prev_upd = rst_n & bus.o_inc_update;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_key(input logic up, input logic v);
        if (up) aumentar = v;
        else    disminuir = v;
    endtask

    task automatic press_release(input logic up);
        set_key(up, 1'b0);
        tick(12);
        set_key(up, 1'b1);
        tick(12);
    endtask

    int lat;
    int p0;
    int q0;

    initial begin
        bus.i_enable      = 1'b1;
        bus.i_tipo_ajuste = 1'b1;
        for (int i = 0; i < NUM_COARSE; i++)
            bus.i_rom_incremento_grueso[i] = 32'(1000 * (i + 1));

        // Reset state and first edge after release
        tick(3);
        check("rst_incremento", bus.o_incremento, 0);
        check("rst_update", bus.o_inc_update, 0);
        check("rst_leds_grueso", leds_grueso, 0);
        check("rst_leds_fino", leds_fino, 0);
        rst_n = 1'b1;
        tick(1);
        check("first_edge_incremento", bus.o_incremento, 1000);
        check("first_edge_leds_grueso", leds_grueso, 3'b001);
        check("first_edge_leds_fino", leds_fino, 3'b000);
        tick(4);

        // Coarse single step with 2-cycle bounce glitches
        aumentar = 1'b0; tick(2);
        aumentar = 1'b1; tick(2);
        aumentar = 1'b0; tick(2);
        aumentar = 1'b1; tick(2);
        p0 = pulse_cnt;
        aumentar = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (bus.o_inc_update) begin
                lat = i;
                break;
            end
        end
        check("step_latency", lat, 8);
        check("step_incremento", bus.o_incremento, 2000);
        tick(1);
        check("update_one_cycle", bus.o_inc_update, 0);
        tick(3);
        aumentar = 1'b1;
        tick(15);
        check("single_step_pulses", pulse_cnt - p0, 1);
        check("single_step_hold", bus.o_incremento, 2000);

        // Coarse hold with auto-repeat up to saturation
        p0 = pulse_cnt;
        q0 = pulse_t.size();
        aumentar = 1'b0;
        tick(300);
        check("hold_leds_grueso", leds_grueso, 3'b010);
        check("sat_incremento", bus.o_incremento, 16000);
        check("sat_pulses", pulse_cnt - p0, 14);
        if (pulse_t.size() >= q0 + 2)
            check("repeat_interval", pulse_t[q0+1] - pulse_t[q0], 16);
        else
            check("repeat_interval", 0, 16);
        aumentar = 1'b1;
        tick(12);
        check("release_leds_grueso", leds_grueso, 3'b001);

        // Fine mode wrap and negative saturation
        rst_n = 1'b0;
        tick(2);
        bus.i_rom_incremento_grueso[0] = 32'd0;
        bus.i_tipo_ajuste = 1'b0;
        rst_n = 1'b1;
        tick(2);
        check("fine_start", bus.o_incremento, 0);
        for (int i = 0; i < 3; i++) press_release(1'b0);
        check("fine_wrap", bus.o_incremento, 32'hFFFF_FFFD);
        check("fine_leds_fino", leds_fino, 3'b001);
        check("fine_leds_grueso", leds_grueso, 3'b000);
        p0 = pulse_cnt;
        disminuir = 1'b0;
        tick(200 * 16);
        check("fine_hold_leds", leds_fino, 3'b100);
        check("fine_sat", bus.o_incremento, 32'hFFFF_FF80);
        check("fine_sat_pulses", pulse_cnt - p0, 125);
        disminuir = 1'b1;
        tick(12);

        // Simultaneous keys
        bus.i_rom_incremento_grueso[0] = 32'd1000;
        bus.i_tipo_ajuste = 1'b1;
        tick(2);
        check("coarse_with_offset", bus.o_incremento, 872);
        p0 = pulse_cnt;
        aumentar  = 1'b0;
        disminuir = 1'b0;
        tick(20);
        check("both_pulses", pulse_cnt - p0, 0);
        check("both_leds", leds_grueso, 3'b001);
        disminuir = 1'b1;
        tick(20);
        check("after_dn_release_pulses", pulse_cnt - p0, 0);
        check("after_dn_release_leds", leds_grueso, 3'b001);
        aumentar = 1'b1;
        tick(12);
        press_release(1'b1);
        check("new_press_incremento", bus.o_incremento, 1872);
        check("new_press_pulses", pulse_cnt - p0, 1);

        // Enable dropped during HOLD_UP
        p0 = pulse_cnt;
        aumentar = 1'b0;
        tick(10);
        check("en_hold_leds", leds_grueso, 3'b010);
        check("en_step", bus.o_incremento, 2872);
        bus.i_enable = 1'b0;
        tick(2);
        check("en_low_leds", leds_grueso, 3'b001);
        tick(40);
        bus.i_enable = 1'b1;
        tick(20);
        check("en_low_pulses", pulse_cnt - p0, 1);
        aumentar = 1'b1;
        tick(12);

        // Mode flip during hold
        p0 = pulse_cnt;
        aumentar = 1'b0;
        tick(10);
        check("mode_step", bus.o_incremento, 3872);
        bus.i_tipo_ajuste = 1'b0;
        tick(3);
        check("mode_leds_grueso", leds_grueso, 3'b000);
        check("mode_leds_fino", leds_fino, 3'b001);
        tick(40);
        check("mode_pulses", pulse_cnt - p0, 1);
        check("mode_incremento", bus.o_incremento, 3872);
        aumentar = 1'b1;
        tick(12);
        bus.i_tipo_ajuste = 1'b1;
        tick(2);

        // Reset in the middle of HOLD_UP at index 5
        press_release(1'b1);
        check("idx4_incremento", bus.o_incremento, 4872);
        aumentar = 1'b0;
        tick(10);
        check("idx5_incremento", bus.o_incremento, 5872);
        check("idx5_leds", leds_grueso, 3'b010);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_incremento", bus.o_incremento, 0);
        check("async_rst_update", bus.o_inc_update, 0);
        check("async_rst_leds_grueso", leds_grueso, 0);
        check("async_rst_leds_fino", leds_fino, 0);
        aumentar = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("post_rst_incremento", bus.o_incremento, 1000);
        check("post_rst_leds_grueso", leds_grueso, 3'b001);
        check("post_rst_leds_fino", leds_fino, 3'b000);

        check("no_double_pulse", dbl_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
